// File: rtl/hex_entry_pkg.sv
// Shared types and constants for the pushbutton hex operand entry block.
package hex_entry_pkg;

  typedef enum logic {
    EDIT = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int NEXT     = 0;
  localparam int INC      = 1;
  localparam int DEC      = 2;
  localparam int ENTER    = 3;
  localparam int NUM_BTNS = 4;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEFAULT_BLINK_CYCLES    = 12_500_000;

  // Steps one nibble up or down modulo 16; neighbouring nibbles never see a carry.
  function automatic logic [31:0] nibble_step(input logic [31:0] value,
                                              input logic [2:0]  idx,
                                              input logic        up);
    logic [31:0] result;
    logic [3:0]  nib;
    result = value;
    nib    = value[{idx, 2'b00} +: 4];
    nib    = up ? nib + 4'd1 : nib - 4'd1;
    result[{idx, 2'b00} +: 4] = nib;
    return result;
  endfunction

endpackage

// File: rtl/hex_operand_entry_button_debounce.sv
// One pushbutton: 2-flop synchronizer, stability counter and a press pulse
// on each debounced rising edge.
module button_debounce
  import hex_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_d;
  logic          lock;
  logic [1:0]    primed;
  logic [CW-1:0] count;

  // lock suppresses presses after reset until a genuine released sample arrives,
  // so a button held through reset must be released before it can fire again.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      lock     <= 1'b1;
      primed   <= 2'b00;
      count    <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      primed   <= {primed[0], 1'b1};
      if (primed[1] && !sync2) lock <= 1'b0;
      if (sync2 != stable) begin
        if (count == CW'(DEBOUNCE_CYCLES)) begin
          stable <= sync2;
          count  <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end else begin
        count <= '0;
      end
    end
  end

  assign press = stable & ~stable_d & ~lock;

endmodule

// File: rtl/hex_operand_entry.sv
// Hex operand editor: four debounced buttons edit a 32-bit number digit by
// digit; enter commits it through a valid/ready handshake.
module hex_operand_entry
  import hex_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int BLINK_CYCLES    = DEFAULT_BLINK_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_next,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        btn_enter,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        out_ready,
  output logic [31:0] number,
  output logic [2:0]  cursor,
  output logic [7:0]  blank_mask,
  output logic [31:0] operand,
  output logic        out_valid
);

  localparam int BW = $clog2(BLINK_CYCLES);

  // Handshake: operand transfers on any edge where out_valid and out_ready are
  // both high; out_valid then drops and stays low until the next enter.
  logic [NUM_BTNS-1:0] raw_btn;
  logic [NUM_BTNS-1:0] press;
  state_t              state;
  logic [BW-1:0]       blink_cnt;
  logic                phase;

  assign raw_btn = {btn_enter, btn_dec, btn_inc, btn_next};

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_btn[i]),
      .press(press[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EDIT;
      number    <= '0;
      cursor    <= '0;
      operand   <= '0;
      out_valid <= 1'b0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      case (state)
        EDIT: begin
          if (load) begin
            number <= load_value;
            cursor <= '0;
          end else if (press[ENTER]) begin
            operand   <= number;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else if (press[INC]) begin
            number <= nibble_step(number, cursor, 1'b1);
          end else if (press[DEC]) begin
            number <= nibble_step(number, cursor, 1'b0);
          end else if (press[NEXT]) begin
            cursor <= cursor + 3'd1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= EDIT;
          end
        end
        default: state <= EDIT;
      endcase
    end
  end

  assign blank_mask = (phase && state == EDIT) ? (8'b1 << cursor) : 8'h00;

endmodule

// File: tb/tb_hex_operand_entry.sv
// Bench for hex_operand_entry: directed scenarios with literal expectations
// plus randomized buttons, all tracked by a window-based behavioural model.
module tb_hex_operand_entry;

  localparam int N = 4;
  localparam int B = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_next = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_enter = 1'b0;
  logic        load = 1'b0;
  logic [31:0] load_value = '0;
  logic        out_ready = 1'b0;
  logic [31:0] number;
  logic [2:0]  cursor;
  logic [7:0]  blank_mask;
  logic [31:0] operand;
  logic        out_valid;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  hex_operand_entry #(
    .DEBOUNCE_CYCLES(N),
    .BLINK_CYCLES   (B)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_next  (btn_next),
    .btn_inc   (btn_inc),
    .btn_dec   (btn_dec),
    .btn_enter (btn_enter),
    .load      (load),
    .load_value(load_value),
    .out_ready (out_ready),
    .number    (number),
    .cursor    (cursor),
    .blank_mask(blank_mask),
    .operand   (operand),
    .out_valid (out_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: a button's debounced level flips once N+1 consecutive
  // synchronized samples disagree with it; the press acts one edge later.
  logic [31:0] samp [4];
  bit          m_stable [4];
  bit          m_lock [4];
  bit          m_press [4];
  bit          all_diff;
  int          m_age, m_t;
  logic [31:0] m_number, m_operand, nib;
  logic [2:0]  m_cursor;
  bit          m_valid;
  bit          model_live = 1'b0;
  logic [3:0]  raw_now;

  always @(posedge clk) begin
    raw_now = {btn_enter, btn_dec, btn_inc, btn_next};
    if (reset) begin
      for (int b = 0; b < 4; b++) begin
        samp[b] = '0; m_stable[b] = 0; m_lock[b] = 1; m_press[b] = 0;
      end
      m_age = 0; m_t = 0; m_number = '0; m_operand = '0; m_cursor = '0; m_valid = 0;
      model_live = 1'b1;
    end else begin
      if (!m_valid) begin
        nib = (m_number >> (4 * m_cursor)) & 32'hF;
        if (load) begin
          m_number = load_value; m_cursor = '0;
        end else if (m_press[3]) begin
          m_operand = m_number; m_valid = 1;
        end else if (m_press[1]) begin
          nib = (nib + 1) % 16;
          m_number = (m_number & ~(32'hF << (4 * m_cursor))) | (nib << (4 * m_cursor));
        end else if (m_press[2]) begin
          nib = (nib + 15) % 16;
          m_number = (m_number & ~(32'hF << (4 * m_cursor))) | (nib << (4 * m_cursor));
        end else if (m_press[0]) begin
          m_cursor = 3'((m_cursor + 1) % 8);
        end
      end else if (out_ready) begin
        m_valid = 0;
      end
      for (int b = 0; b < 4; b++) begin
        samp[b] = {samp[b][30:0], raw_now[b]};
        if (m_age >= 2 && samp[b][2] == 1'b0) m_lock[b] = 0;
        all_diff = 1;
        for (int j = 2; j <= N + 2; j++) if (samp[b][j] == m_stable[b]) all_diff = 0;
        m_press[b] = 0;
        if (all_diff) begin
          m_stable[b] = !m_stable[b];
          m_press[b]  = m_stable[b] && !m_lock[b];
        end
      end
      m_age++;
      m_t++;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("number", number, m_number);
      check("cursor", {29'd0, cursor}, {29'd0, m_cursor});
      check("operand", operand, m_operand);
      check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      check("blank_mask", {24'd0, blank_mask},
            (((m_t / B) % 2) == 1 && !m_valid) ? (32'd1 << m_cursor) : 32'd0);
    end
  end

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_next = v;
      1: btn_inc = v;
      2: btn_dec = v;
      default: btn_enter = v;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic press_btn(input int b);
    @(negedge clk) set_btn(b, 1'b1);
    repeat (8) @(negedge clk);
    set_btn(b, 1'b0);
    repeat (8) @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] v);
    @(negedge clk) begin load = 1'b1; load_value = v; end
    @(negedge clk) load = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          hi;
    int          k;
    int          rem [4];
    logic [4:0]  pat;

    // Reset values
    do_reset();
    check("rst_number", number, 32'h0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_blank", {24'd0, blank_mask}, 32'd0);

    // Held button: one event at edge N+3, none on hold or release
    idle(3);
    btn_inc = 1'b1;
    repeat (7) @(posedge clk);
    #1 check("held_edge6", number, 32'h0);
    @(posedge clk);
    #1 check("held_edge7", number, 32'h1);
    repeat (12) @(negedge clk);
    check("held_steady", number, 32'h1);
    btn_inc = 1'b0;
    idle(10);
    check("held_release", number, 32'h1);

    // Bounce rejection
    do_reset();
    idle(3);
    pat = 5'b10101;
    for (int i = 0; i < 5; i++) @(negedge clk) btn_inc = pat[i];
    @(negedge clk) btn_inc = 1'b0;
    idle(12);
    check("bounce", number, 32'h0);

    // Cursor and nibble wrap
    do_reset();
    idle(3);
    repeat (3) press_btn(0);
    repeat (2) press_btn(1);
    check("wrap_cursor3", {29'd0, cursor}, 32'd3);
    check("wrap_num2000", number, 32'h0000_2000);
    repeat (5) press_btn(0);
    check("wrap_cursor0", {29'd0, cursor}, 32'd0);
    press_btn(2);
    check("wrap_dec", number, 32'h0000_200F);
    press_btn(1);
    check("wrap_inc", number, 32'h0000_2000);

    // Handshake hold
    do_load(32'h3F80_0000);
    check("load", number, 32'h3F80_0000);
    press_btn(3);
    check("hs_valid", {31'd0, out_valid}, 32'd1);
    check("hs_operand", operand, 32'h3F80_0000);
    press_btn(1);
    check("hs_hold_num", number, 32'h3F80_0000);
    check("hs_hold_valid", {31'd0, out_valid}, 32'd1);
    check("hs_hold_op", operand, 32'h3F80_0000);
    @(negedge clk) out_ready = 1'b1;
    @(negedge clk) out_ready = 1'b0;
    check("hs_release", {31'd0, out_valid}, 32'd0);
    press_btn(1);
    check("hs_edit_again", number, 32'h3F80_0001);

    // Priority and blink
    do_reset();
    idle(3);
    @(negedge clk) begin btn_inc = 1'b1; btn_dec = 1'b1; end
    repeat (8) @(negedge clk);
    btn_inc = 1'b0; btn_dec = 1'b0;
    idle(8);
    check("prio_inc", number, 32'h1);
    repeat (2) press_btn(0);
    hi = 0;
    repeat (16) begin
      @(negedge clk);
      if (blank_mask == 8'h04) hi++;
    end
    check("blink_duty", hi, 32'd8);
    press_btn(3);
    hi = 0;
    repeat (16) begin
      @(negedge clk);
      if (blank_mask != 8'h00) hi++;
    end
    check("blink_hold", hi, 32'd0);
    @(negedge clk) out_ready = 1'b1;
    @(negedge clk) out_ready = 1'b0;

    // Reset mid-HOLD with enter held through reset
    do_reset();
    idle(3);
    do_load(32'hDEAD_BEEF);
    @(negedge clk) btn_enter = 1'b1;
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rh_enter", {31'd0, out_valid}, 32'd1);
    do_reset();
    idle(20);
    check("rh_valid", {31'd0, out_valid}, 32'd0);
    check("rh_number", number, 32'h0);
    check("rh_operand", operand, 32'h0);
    btn_enter = 1'b0;
    idle(10);
    check("rh_still_edit", {31'd0, out_valid}, 32'd0);
    press_btn(3);
    check("rh_repress", {31'd0, out_valid}, 32'd1);
    @(negedge clk) out_ready = 1'b1;
    @(negedge clk) out_ready = 1'b0;

    // Randomized traffic, checked cycle by cycle against the model
    for (int b = 0; b < 4; b++) rem[b] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int b = 0; b < 4; b++) begin
        if (rem[b] == 0) begin
          set_btn(b, 1'($urandom_range(0, 1)));
          rem[b] = $urandom_range(1, 12);
        end else begin
          rem[b]--;
        end
      end
      load       = ($urandom_range(0, 15) == 0);
      load_value = $urandom;
      out_ready  = ($urandom_range(0, 3) == 0);
      reset      = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk) begin
      btn_next = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; btn_enter = 1'b0;
      load = 1'b0; out_ready = 1'b0; reset = 1'b0;
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hex_operand_entry.md
# hex_operand_entry

Pushbutton-driven hex operand entry for the floating-point ALU board build. It lets a user compose a 32-bit operand one hex digit at a time, using four debounced buttons and a blinking cursor digit. The finished operand is handed to the ALU front end through a valid/ready handshake. Its `number` and `blank_mask` outputs feed the board's eight-digit seven-segment display driver, which is the write side of the same display/operand path.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required before a button change is accepted (20 ms at 50 MHz).
- `BLINK_CYCLES`, default 12_500_000: cycles per blink half-period of the cursor digit (2 Hz at 50 MHz).
- `clk` in 1: 50 MHz system clock.
- `reset` in 1: reset, synchronous, active-high.
- `btn_next`, `btn_inc`, `btn_dec`, `btn_enter` in 1 each: raw asynchronous pushbuttons, active-high.
- `load` in 1: one-cycle preload strobe.
- `load_value` in 32: value taken when `load` is high.
- `out_ready` in 1: consumer accepts the operand.
- `number` out 32: value currently being edited.
- `cursor` out 3: index of the digit being edited; 0 is the least significant nibble.
- `blank_mask` out 8: bit i high means display digit i is blanked.
- `operand` out 32: committed operand.
- `out_valid` out 1: `operand` is valid.

## Operation
- **Button front end**, applied per button:
  - 2-flop synchronizer.
  - Debounce counter: counts while the synchronized value differs from the stable value and clears when they are equal. When the count reaches `DEBOUNCE_CYCLES`, the stable value takes the new level.
  - A stable 0→1 transition produces a one-cycle press event. Releases produce no event, and there is no auto-repeat.
- **States:** EDIT and HOLD.
- **EDIT:**
  - `load` sets `number`=`load_value` and `cursor`=0.
  - Otherwise one press event is applied, with priority enter > inc > dec > next. Lower-priority events in the same cycle are dropped.
  - inc: nibble[cursor] +1 mod 16. F wraps to 0 with no carry into other nibbles.
  - dec: nibble[cursor] −1 mod 16. 0 wraps to F with no borrow.
  - next: `cursor` +1 mod 8, so 7 wraps to 0.
  - enter: `operand`←`number`, `out_valid`←1, go to HOLD.
- **HOLD:**
  - `out_valid`=1 and `operand` is stable.
  - All press events and `load` are ignored.
  - When `out_ready`=1, `out_valid`←0 and the block returns to EDIT. `number` and `cursor` are retained for further edits.
- `out_ready` is ignored while in EDIT.
- **Blink:**
  - Free-running counter 0..`BLINK_CYCLES`−1 toggles a phase bit on wrap.
  - `blank_mask` = (phase & EDIT) ? (1<<`cursor`) : 0. In HOLD all digits are shown steady.
- **Reset:** applies mid-edit or mid-HOLD and clears everything, including debounce state, so a button already held through reset produces no event until it is released and pressed again.

## Timing
- **Reset values:** `number`=0, `cursor`=0, `operand`=0, `out_valid`=0, `blank_mask`=0. Internally: state EDIT, synchronizers 0, stable values 0, counters 0, phase 0.
- **Press latency:** with N=`DEBOUNCE_CYCLES`, a raw rise first sampled at edge 0 updates `number`/`cursor`/`out_valid` at edge N+3, made up of 2 synchronizer edges, N debounce edges and 1 action edge.
- **Bounce rejection:** any bounce shorter than N cycles produces no event.
- **Load latency:** `number` updates on the edge that samples `load`=1.
- **Handshake:** a transfer occurs on an edge where `out_valid` & `out_ready` are both 1. `out_valid` is low from the next cycle. The minimum HOLD duration is 1 cycle.
- **Output registration:** all outputs are registered except `blank_mask`, which is combinational from registered phase, state and `cursor`.

## Structure
- **Package `hex_entry_pkg`:**
  - state enum {EDIT, HOLD};
  - button index constants NEXT=0, INC=1, DEC=2, ENTER=3;
  - default debounce and blink constants.
- **Sub-module `button_debounce`:** synchronizer, debounce counter and rising-edge pulse, parameterized by `DEBOUNCE_CYCLES`. It is instantiated four times.
- **Top level:** the FSM, nibble arithmetic and blink counter.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `BLINK_CYCLES`=8.
- **Held button:** reset, then hold `btn_inc` high 20 cycles → `number`=0x00000001 at edge 7 and unchanged thereafter; release gives no change.
- **Bounce rejection:** `btn_inc` pattern 1,0,1,0,1 (one cycle each) then 0 → `number` stays 0x00000000.
- **Cursor and nibble wrap:** next ×3, inc ×2 → `cursor`=3, `number`=0x00002000. Then next ×5 → `cursor`=0; dec → `number`=0x0000200F; inc → 0x00002000 with no carry into nibble 1.
- **Handshake hold:** `load` 0x3F800000, then enter → `out_valid`=1, `operand`=0x3F800000. With `out_ready`=0 for 6 cycles, `out_valid` and `operand` hold, and an inc press leaves `number` unchanged. With `out_ready`=1 for 1 cycle, `out_valid`=0 on the next cycle and the block is back in EDIT.
- **Priority and blink:** same-cycle inc and dec events → only inc is applied. In EDIT with `cursor`=2, `blank_mask` alternates 0x00/0x04 every 8 cycles; in HOLD it reads 0x00.
- **Reset mid-HOLD:** reset asserted while `btn_enter` is held → all outputs return to reset values, and no event occurs until the button is released and pressed again.
